// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared defaults and controller command layout for the BIST datapath
//
// Contents:
//   BIST_WIDTH / BIST_POLY / BIST_GOLDEN  default parameter values
//   CMD_*_BIT, CMD_W                      bit positions of the controller command word
//   bist_op_e, decode_cmd()               prioritised decode of the command word
package bist_pkg;

    localparam int         BIST_WIDTH  = 4;
    localparam logic [3:0] BIST_POLY   = 4'b0011;
    localparam logic [3:0] BIST_GOLDEN = 4'b0000;

    // Command word as driven by the controller: {reset, preset, en}.
    localparam int CMD_W          = 3;
    localparam int CMD_RESET_BIT  = 2;
    localparam int CMD_PRESET_BIT = 1;
    localparam int CMD_EN_BIT     = 0;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_STEP   = 2'd1,
        OP_PRESET = 2'd2,
        OP_CLEAR  = 2'd3
    } bist_op_e;

    // reset beats preset beats en; a command cycle swallows en.
    function automatic bist_op_e decode_cmd(input logic [CMD_W-1:0] cmd);
        if (cmd[CMD_RESET_BIT])
            return OP_CLEAR;
        else if (cmd[CMD_PRESET_BIT])
            return OP_PRESET;
        else if (cmd[CMD_EN_BIT])
            return OP_STEP;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - Galois-form multiple-input signature register
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   clear  in   clear signature on next edge
//   en     in   compact data into signature on next edge
//   data   in   WIDTH  parallel response word
//   sig    out  WIDTH  current signature (registered)
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = BIST_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] next_sig;

    // Shift left, fold the outgoing MSB back through the taps, then mix in data.
    always_comb begin
        next_sig = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            sig <= '0;
        else if (en)
            sig <= next_sig;
        else
            sig <= sig;
    end

endmodule

// File: rtl/bist_datapath.sv
// rtl/bist_datapath.sv - BIST pattern counter, response MISR and pass/terminal-count flags
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   reset     in   command: clear counter and MISR
//   preset    in   command: counter to all-ones, clear MISR
//   en        in   command: advance counter and compact cut_resp
//   up_down   in   count direction, 1 = up
//   cut_resp  in   WIDTH  CUT response to the current pattern
//   pattern   out  WIDTH  test pattern (counter register)
//   carry     out  terminal count for the controller
//   is_equal  out  signature equals GOLDEN
//   out       out  serial signature bit (MISR MSB)
module bist_datapath
    import bist_pkg::*;
#(
    parameter int               WIDTH  = BIST_WIDTH,
    parameter logic [WIDTH-1:0] POLY   = BIST_POLY,
    parameter logic [WIDTH-1:0] GOLDEN = BIST_GOLDEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] cut_resp,
    output logic [WIDTH-1:0] pattern,
    output logic             carry,
    output logic             is_equal,
    output logic             out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    bist_op_e         op;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] misr_sig;

    assign op = decode_cmd({reset, preset, en});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (op)
                OP_CLEAR:  cnt <= '0;
                OP_PRESET: cnt <= '1;
                OP_STEP:   cnt <= up_down ? cnt + ONE : cnt - ONE;
                default:   cnt <= cnt;
            endcase
        end
    end

    // cut_resp is compacted on the same edge the counter leaves the pattern
    // that produced it.
    bist_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear ((op == OP_CLEAR) || (op == OP_PRESET)),
        .en    (op == OP_STEP),
        .data  (cut_resp),
        .sig   (misr_sig)
    );

    assign pattern  = cnt;
    assign out      = misr_sig[WIDTH-1];
    assign is_equal = (misr_sig == GOLDEN);

    // Held low during rst so the controller never sees a terminal count
    // from a counter that is being forced to zero.
    assign carry = en && !rst && (up_down ? (cnt == '1) : (cnt == '0));

endmodule

// File: tb/tb_bist_datapath.sv
// tb/tb_bist_datapath.sv - directed vector bench for bist_datapath
module tb_bist_datapath;

    logic       clk;
    logic       rst;
    logic       reset;
    logic       preset;
    logic       en;
    logic       up_down;
    logic [3:0] cut_resp;
    logic [3:0] pattern;
    logic       carry;
    logic       is_equal;
    logic       out;

    int checks = 0;
    int errors = 0;

    bist_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .reset    (reset),
        .preset   (preset),
        .en       (en),
        .up_down  (up_down),
        .cut_resp (cut_resp),
        .pattern  (pattern),
        .carry    (carry),
        .is_equal (is_equal),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one cycle; expected outputs are the values seen
    // during that cycle, i.e. before the edge that consumes the inputs.
    typedef struct {
        logic       rst;
        logic       reset;
        logic       preset;
        logic       en;
        logic       up_down;
        logic [3:0] resp;
        logic [3:0] pat;
        logic       carry;
        logic       eq;
        logic       out;
        logic [3:0] misr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rs, input logic ps,
                                input logic e, input logic ud, input logic [3:0] resp,
                                input logic [3:0] pat, input logic cy, input logic eq,
                                input logic o, input logic [3:0] misr);
        vec_t v;
        v.rst = r; v.reset = rs; v.preset = ps; v.en = e; v.up_down = ud; v.resp = resp;
        v.pat = pat; v.carry = cy; v.eq = eq; v.out = o; v.misr = misr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rs, input logic ps,
                         input logic e, input logic ud, input logic [3:0] resp);
        rst = r; reset = rs; preset = ps; en = e; up_down = ud; cut_resp = resp;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 4'h0);

        //   rst rs ps en ud resp   pat cy eq o misr
        add(1, 0, 0, 0, 0, 4'h0,   4'h0, 0, 1, 0, 4'h0);
        add(1, 0, 0, 1, 0, 4'h5,   4'h0, 0, 1, 0, 4'h0);   // rst beats en, no carry
        add(0, 1, 0, 0, 1, 4'h0,   4'h0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 16; i++)
            add(0, 0, 0, 1, 1, 4'h0, 4'(i), (i == 15), 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 4'h0,   4'h0, 0, 1, 0, 4'h0);   // wrapped F -> 0, hold
        add(0, 0, 1, 0, 0, 4'h0,   4'h0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 16; i++)
            add(0, 0, 0, 1, 0, 4'h0, 4'(15 - i), (i == 15), 1, 0, 4'h0);
        add(0, 0, 0, 0, 0, 4'h0,   4'hF, 0, 1, 0, 4'h0);   // wrapped 0 -> F
        add(0, 1, 0, 0, 1, 4'h0,   4'hF, 0, 1, 0, 4'h0);
        add(0, 0, 0, 1, 1, 4'h1,   4'h0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 1, 1, 4'h0,   4'h1, 0, 0, 0, 4'h1);
        add(0, 0, 0, 1, 1, 4'h0,   4'h2, 0, 0, 0, 4'h2);
        add(0, 0, 0, 1, 1, 4'h0,   4'h3, 0, 0, 0, 4'h4);
        add(0, 0, 0, 1, 1, 4'h0,   4'h4, 0, 0, 1, 4'h8);   // feedback fires next
        add(0, 0, 0, 0, 1, 4'h0,   4'h5, 0, 0, 0, 4'h3);
        add(0, 0, 0, 1, 1, 4'hA,   4'h5, 0, 0, 0, 4'h3);
        add(0, 0, 0, 1, 1, 4'h1,   4'h6, 0, 0, 1, 4'hC);
        add(0, 1, 1, 1, 1, 4'hF,   4'h7, 0, 0, 1, 4'hA);   // reset+preset+en -> reset
        add(0, 0, 0, 1, 1, 4'h0,   4'h0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 1, 1, 4'h0,   4'h1, 0, 1, 0, 4'h0);
        add(0, 0, 1, 1, 0, 4'h6,   4'h2, 0, 1, 0, 4'h0);   // preset swallows en
        add(0, 0, 0, 1, 0, 4'h0,   4'hF, 0, 1, 0, 4'h0);
        add(1, 0, 1, 1, 1, 4'h3,   4'hE, 0, 1, 0, 4'h0);   // lone rst mid-count
        add(0, 0, 0, 0, 1, 4'h0,   4'h0, 0, 1, 0, 4'h0);

        @(posedge clk);
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].reset, vecs[k].preset, vecs[k].en,
                  vecs[k].up_down, vecs[k].resp);
            #1;
            chk("pattern",  k, pattern,              vecs[k].pat);
            chk("carry",    k, {3'b0, carry},        {3'b0, vecs[k].carry});
            chk("is_equal", k, {3'b0, is_equal},     {3'b0, vecs[k].eq});
            chk("out",      k, {3'b0, out},          {3'b0, vecs[k].out});
            chk("misr",     k, dut.misr_sig,         vecs[k].misr);
        end

        // Responses 1,2,4,8 cancel back to a zero signature; is_equal must
        // drop after the first step and be true the cycle after the last.
        @(negedge clk); drive(0, 1, 0, 0, 1, 4'h0);
        @(negedge clk); drive(0, 0, 0, 1, 1, 4'h1);
        @(negedge clk); drive(0, 0, 0, 1, 1, 4'h2);
        #1;
        chk("seq_mid_eq", 0, {3'b0, is_equal}, 4'h0);
        chk("seq_mid_misr", 0, dut.misr_sig, 4'h1);
        @(negedge clk); drive(0, 0, 0, 1, 1, 4'h4);
        @(negedge clk); drive(0, 0, 0, 1, 1, 4'h8);
        @(negedge clk); drive(0, 0, 0, 0, 1, 4'h0);
        #1;
        chk("seq_end_eq", 1, {3'b0, is_equal}, 4'h1);
        chk("seq_end_misr", 1, dut.misr_sig, 4'h0);
        chk("seq_end_pattern", 1, pattern, 4'h4);

        // Down count reaching 0 raises carry combinationally with en.
        @(negedge clk); drive(0, 1, 0, 0, 0, 4'h0);
        @(negedge clk); drive(0, 0, 0, 1, 0, 4'h0);
        #1;
        chk("seq_down_carry", 2, {3'b0, carry}, 4'h1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 4'h0);
        #1;
        chk("seq_down_carry_off", 3, {3'b0, carry}, 4'h0);
        chk("seq_down_wrap", 3, pattern, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_datapath.md
BIST_DATAPATH -- requirements
Module: bist_datapath

Interface
REQ-001 Parameter WIDTH, default 4: pattern counter and signature register width.
REQ-002 Parameter POLY, default 4'b0011: MISR feedback taps (x^4+x+1, Galois form).
REQ-003 Parameter GOLDEN, default 4'b0000: expected final signature.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 reset  input  1  controller command: clear counter and MISR.
REQ-007 preset  input  1  controller command: counter to all-ones, clear MISR.
REQ-008 en  input  1  controller command: advance counter and compact response.
REQ-009 up_down  input  1  count direction, 1 = up, 0 = down.
REQ-010 cut_resp  input  WIDTH  circuit-under-test response to current pattern.
REQ-011 pattern  output  WIDTH  test pattern to the CUT, equal to the counter register.
REQ-012 carry  output  1  terminal-count indication to the controller.
REQ-013 is_equal  output  1  signature matches GOLDEN.
REQ-014 out  output  1  serial signature bit, MISR[WIDTH-1].

Function
REQ-015 Per-edge priority SHALL be rst > reset > preset > en > hold.
REQ-016 reset SHALL set counter and MISR to 0 on the next edge.
REQ-017 preset SHALL set the counter to all-ones and the MISR to 0 on the next edge.
REQ-018 en with up_down=1 SHALL increment the counter modulo 2^WIDTH; all-ones wraps to 0.
REQ-019 en with up_down=0 SHALL decrement the counter modulo 2^WIDTH; 0 wraps to all-ones.
REQ-020 With en=0 and no command, counter and MISR SHALL hold.
REQ-021 On an en edge, MISR SHALL load {MISR[WIDTH-2:0],1'b0} XOR (MISR[WIDTH-1] ? POLY : 0) XOR cut_resp.
REQ-022 cut_resp SHALL be sampled on the same edge the counter advances, so the response pairs with the pattern present before that edge.
REQ-023 carry SHALL be combinational: en AND ((up_down AND counter==all-ones) OR (NOT up_down AND counter==0)).
REQ-024 is_equal SHALL be combinational: MISR == GOLDEN, valid the cycle after the last en edge.
REQ-025 out and pattern SHALL be driven directly from registers; they carry no combinational input paths.
REQ-026 reset and preset asserted together SHALL behave as reset alone.
REQ-027 A command SHALL take effect in the same cycle it is asserted mid-sequence; en asserted in that cycle is ignored.

Reset
REQ-028 While rst=1, counter and MISR SHALL be 0; pattern=0, out=0 and carry=0.
REQ-029 is_equal after rst SHALL equal (GOLDEN==0).
REQ-030 rst SHALL override every command and every in-flight sequence on the same edge.
REQ-031 The block SHALL hold no asynchronous reset and no unreset flops.

Structure
REQ-032 Package bist_pkg SHALL hold the WIDTH, POLY and GOLDEN defaults and the controller/datapath command bit layout.
REQ-033 Sub-module bist_misr SHALL implement the MISR: clear, enable, data in, and signature out.
REQ-034 The counter, carry and is_equal logic SHALL remain in bist_datapath.

Verification
REQ-035 rst=1 for 2 cycles -> pattern=0, out=0, carry=0, is_equal=1 (GOLDEN=0).
REQ-036 reset, then en+up_down=1 for 16 cycles -> pattern 0..F, carry=1 only while pattern=F, then pattern wraps to 0.
REQ-037 preset, then en+up_down=0 for 16 cycles -> pattern F..0, carry=1 only while pattern=0, then pattern wraps to F.
REQ-038 reset; en with cut_resp=1, then en with cut_resp=0 -> MISR 0001 then 0010; is_equal=0; out=0.
REQ-039 MISR=1000 with en and cut_resp=0 -> MISR=0011 and out goes 1 -> 0.
REQ-040 reset, preset and en all high at pattern=7 -> next pattern=0 and MISR=0; a lone rst mid-count -> pattern=0 on the next edge.
